// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// Takes signed 33-bit filter results on a valid/ready handshake, scales them
// by an arithmetic right shift, reduces them to 24-bit audio and sends each
// sample in both slots of one I2S frame. The frame is 64 BCLKs long: in each
// 32-bit slot there are 24 data bits, MSB first, followed by 8 zero bits.
// BCLK and LRCLK are derived from clk.
//
// Build option:
//   I2S_TX_SATURATE_EN  defined     -> clamp to [0x800000, 0x7FFFFF]
//                       not defined -> keep the low 24 bits (wraps on overflow)
module i2s_tx_serializer #(
    parameter int CLK_DIV = 4,   // clk cycles per BCLK half-period (>= 2)
    parameter int SHIFT   = 8    // arithmetic right shift before reduction (0..9)
) (
    input  logic        clk,
    input  logic        reset,           // asynchronous, active-low
    input  logic        en_i,
    input  logic [32:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sdata_o,
    output logic        frame_start_o,
    output logic        underrun_o,
    output logic        overrun_o
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Sample scaling
    // ------------------------------------------------------------------
    logic signed [32:0] sample_s;
    logic        [23:0] scaled;

    assign sample_s = sample_i;

`ifdef I2S_TX_SATURATE_EN
    logic signed [32:0] shifted;

    assign shifted = sample_s >>> SHIFT;

    // Clamp to the 24-bit range. The value fits only when bits 32..23 all
    // match the sign bit.
    always_comb begin
        // NOTE: every signal written here gets a default first; otherwise
        // a path that does not assign it would infer a latch.
        scaled = shifted[23:0];
        if (shifted[32:23] != {10{shifted[32]}}) begin
            scaled = shifted[32] ? 24'h800000 : 24'h7FFFFF;
        end
    end
`else
    // Plain truncation; large values wrap.
    assign scaled = 24'(sample_s >>> SHIFT);
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [31:0]      shift_q, shift_d;
    logic [23:0]      hold_q, hold_d;
    logic             full_q, full_d;
    logic [23:0]      last_q, last_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Events
    // ------------------------------------------------------------------
    logic        tick;       // end of a BCLK half-period
    logic        fall;       // BCLK is about to go 1 -> 0
    logic        load_l;     // bit counter wraps 63 -> 0: a new frame begins
    logic        load_r;     // bit counter 31 -> 32: the right slot begins
    logic        accept;     // handshake completes this clk
    logic [23:0] load_word;  // word that starts the new frame

    assign tick   = en_i & (div_q == DIV_LAST);
    assign fall   = tick & bclk_q;
    assign load_l = fall & (bit_cnt_q == 6'd63);
    assign load_r = fall & (bit_cnt_q == 6'd31);
    assign accept = sample_valid_i & ~full_q;

    // Pick the frame word: the held sample first, then a sample that arrives
    // on the load clk itself, and otherwise the previous word again.
    always_comb begin
        load_word = last_q;
        if (full_q) begin
            load_word = hold_q;
        end else if (sample_valid_i) begin
            load_word = scaled;
        end
    end

    // Next-state logic: divider, bit clock, serializer and holding register.
    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        bit_cnt_d     = bit_cnt_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        full_d        = full_q;
        last_d        = last_q;
        frame_start_d = load_l;
        underrun_d    = underrun_q | (load_l & ~full_q & ~sample_valid_i);
        overrun_d     = overrun_q | (sample_valid_i & full_q);

        if (en_i) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            bclk_d = ~bclk_q;
        end

        // Each falling edge drives the current MSB of the shift register.
        // At a slot boundary that MSB is still the previous slot's last
        // (zero) bit, which gives the I2S one-bit delay.
        if (fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            sdata_d   = shift_q[31];
            shift_d   = {shift_q[30:0], 1'b0};
            if (load_l) begin
                shift_d = {load_word, 8'h00};
                lrclk_d = 1'b0;
            end else if (load_r) begin
                shift_d = {last_q, 8'h00};
                lrclk_d = 1'b1;
            end
        end

        // A sample that arrives on the load clk bypasses the holding register.
        if (load_l) begin
            last_d = load_word;
            full_d = 1'b0;
        end else if (accept) begin
            hold_d = scaled;
            full_d = 1'b1;
        end
    end

    // State registers; reset abandons any word that is being sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= 6'd0;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            shift_q       <= 32'h0;
            hold_q        <= 24'h0;
            full_q        <= 1'b0;
            last_q        <= 24'h0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so that every register in this
            // block samples the values from before the clock edge.
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            full_q        <= full_d;
            last_q        <= last_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign sample_ready_o = ~full_q;
    assign bclk_o         = bclk_q;
    assign lrclk_o        = lrclk_q;
    assign sdata_o        = sdata_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_o     = underrun_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (CLK_DIV=4, SHIFT=8). The DUT is
// sampled on the falling edge of clk. Each frame is captured on the rising
// edges of BCLK: rise 0 carries the bit driven at the LRCLK edge, rises 1..32
// carry the left slot and rises 33..63 carry the right slot minus its last bit.
module tb_i2s_tx_serializer;

    logic        clk;
    logic        reset;
    logic        en_i;
    logic [32:0] sample_i;
    logic        sample_valid_i;
    logic        sample_ready_o;
    logic        bclk_o;
    logic        lrclk_o;
    logic        sdata_o;
    logic        frame_start_o;
    logic        underrun_o;
    logic        overrun_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

`ifdef I2S_TX_SATURATE_EN
    localparam logic [23:0] W_NEG = 24'h800000;
    localparam logic [23:0] W_POS = 24'h7FFFFF;
`else
    localparam logic [23:0] W_NEG = 24'h000000;
    localparam logic [23:0] W_POS = 24'hFFFFFF;
`endif
    localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

    i2s_tx_serializer #(.CLK_DIV(4), .SHIFT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .en_i           (en_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .bclk_o         (bclk_o),
        .lrclk_o        (lrclk_o),
        .sdata_o        (sdata_o),
        .frame_start_o  (frame_start_o),
        .underrun_o     (underrun_o),
        .overrun_o      (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Serial image of one frame carrying w: leading zero, left slot, right slot minus its last bit.
    function automatic logic [63:0] frame_bits(input logic [23:0] w);
        logic [31:0] s;
        s = {w, 8'h00};
        return {1'b0, s, s[31:1]};
    endfunction

    task automatic wait_fs(input string tag);
        int n;
        n = -1;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (frame_start_o === 1'b1) begin
                n = i;
                break;
            end
        end
        check(tag, 64'(n > 0), 64'd1);
    endtask

    task automatic capture(input string tag, output logic [63:0] bits, output logic [63:0] lr);
        logic prev;
        int   got;
        bits = '0;
        lr   = '0;
        got  = 0;
        prev = bclk_o;
        for (int i = 0; i < 700 && got < 64; i++) begin
            @(negedge clk);
            if (bclk_o === 1'b1 && prev === 1'b0) begin
                bits[63-got] = sdata_o;
                lr[63-got]   = lrclk_o;
                got++;
            end
            prev = bclk_o;
        end
        check(tag, 64'(got), 64'd64);
    endtask

    task automatic send(input logic [32:0] s);
        sample_i       = s;
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
    endtask

    logic [63:0] bits, lr;
    int rise1, rise2, fs_k;
    logic lr_early_low;

    initial begin
        reset          = 1'b0;
        en_i           = 1'b1;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        // Outputs held at their reset values.
        check("rst_bclk",  64'(bclk_o),         64'd0);
        check("rst_lrclk", 64'(lrclk_o),        64'd1);
        check("rst_sdata", 64'(sdata_o),        64'd0);
        check("rst_ready", 64'(sample_ready_o), 64'd1);
        check("rst_fs",    64'(frame_start_o),  64'd0);
        check("rst_under", 64'(underrun_o),     64'd0);
        check("rst_over",  64'(overrun_o),      64'd0);

        // Release reset; time the first frame and load sample A (0x1200 -> 0x000012).
        reset = 1'b1;
        rise1 = -1; rise2 = -1; fs_k = -1;
        lr_early_low = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            logic prev_b;
            prev_b = bclk_o;
            @(negedge clk);
            if (bclk_o === 1'b1 && prev_b === 1'b0) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            if (k == 100) begin
                sample_i       = 33'h000001200;
                sample_valid_i = 1'b1;
            end
            if (k == 101) begin
                sample_valid_i = 1'b0;
                check("ready_after_accept", 64'(sample_ready_o), 64'd0);
            end
            if (frame_start_o === 1'b1) begin
                fs_k = k;
                break;
            end
            if (lrclk_o !== 1'b1) lr_early_low = 1'b1;
        end
        check("first_bclk_rise",  64'(rise1), 64'd4);
        check("bclk_period",      64'(rise2 - rise1), 64'd8);
        check("first_fs_clk",     64'(fs_k),  64'd512);
        check("lrclk_high_before", 64'(lr_early_low), 64'd0);
        check("lrclk_low_at_fs",  64'(lrclk_o), 64'd0);
        check("f1_ready",         64'(sample_ready_o), 64'd1);

        // Frame 1 carries A. Load B (most negative) during it.
        send(33'h100000000);
        capture("f1_cap", bits, lr);
        check("f1_bits", bits, frame_bits(24'h000012));
        check("f1_lr",   lr,   LR_EXP);

        // Frame 2 carries B. Send C, then D back-to-back; D is dropped.
        wait_fs("f2_fs");
        check("f2_over0", 64'(overrun_o), 64'd0);
        sample_i       = 33'h0FFFFFFFF;
        sample_valid_i = 1'b1;
        @(negedge clk);
        check("f2_ready_low", 64'(sample_ready_o), 64'd0);
        sample_i = 33'h000003400;
        @(negedge clk);
        sample_valid_i = 1'b0;
        check("f2_overrun", 64'(overrun_o), 64'd1);
        check("f2_ready_still_low", 64'(sample_ready_o), 64'd0);
        capture("f2_cap", bits, lr);
        check("f2_bits", bits, frame_bits(W_NEG));
        check("f2_lr",   lr,   LR_EXP);

        // Frame 3 carries C. Afterwards send E on the exact load clk (bypass).
        wait_fs("f3_fs");
        check("f3_ready", 64'(sample_ready_o), 64'd1);
        capture("f3_cap", bits, lr);
        check("f3_bits", bits, frame_bits(W_POS));
        repeat (3) @(negedge clk);
        sample_i       = 33'h0000ABC00;
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
        check("f4_fs_bypass", 64'(frame_start_o), 64'd1);
        check("f4_ready",     64'(sample_ready_o), 64'd1);
        check("f4_no_under",  64'(underrun_o), 64'd0);
        capture("f4_cap", bits, lr);
        check("f4_bits", bits, frame_bits(24'h000ABC));

        // Frame 5: nothing is sent, so E repeats and underrun sets.
        wait_fs("f5_fs");
        check("f5_underrun", 64'(underrun_o), 64'd1);
        capture("f5_cap", bits, lr);
        check("f5_bits", bits, frame_bits(24'h000ABC));
        check("f5_lr",   lr,   LR_EXP);

        // Frame 6: freeze with en_i low after fall 13, where sdata shows bit 11 of 0x000ABC (1).
        wait_fs("f6_fs");
        repeat (106) @(negedge clk);
        en_i = 1'b0;
        repeat (20) @(negedge clk);
        check("en_bclk",  64'(bclk_o),  64'd0);
        check("en_lrclk", 64'(lrclk_o), 64'd0);
        check("en_sdata", 64'(sdata_o), 64'd1);
        send(33'h000005600);
        check("en_handshake", 64'(sample_ready_o), 64'd0);
        en_i = 1'b1;
        repeat (5) @(negedge clk);

        // Reset asserted mid-left-slot, between clock edges.
        #2 reset = 1'b0;
        #1;
        check("mid_rst_bclk",  64'(bclk_o),         64'd0);
        check("mid_rst_lrclk", 64'(lrclk_o),        64'd1);
        check("mid_rst_sdata", 64'(sdata_o),        64'd0);
        check("mid_rst_ready", 64'(sample_ready_o), 64'd1);
        check("mid_rst_fs",    64'(frame_start_o),  64'd0);
        check("mid_rst_under", 64'(underrun_o),     64'd0);
        check("mid_rst_over",  64'(overrun_o),      64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Output end of the equalizer datapath: accepts signed 33-bit filter results from the dsp block on a valid/ready handshake, scales and saturates them to 24-bit audio, and serializes them onto an I2S link toward the DAC. Acts as the transmitter counterpart to the 24-bit sample input feeding `signalwindow`. Generates its own BCLK/LRCLK from the system clock. Mono path: each accepted sample is sent in both the left and the right slot of one frame.

## Interface
Parameters:
- `CLK_DIV`, 4, clk cycles per BCLK half-period (≥2)
- `SHIFT`, 8, arithmetic right shift applied to `sample_i` before saturation (0–9)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `en_i`  in  1  clock enable; low freezes all state and outputs
- `sample_i`  in  33  signed filter result
- `sample_valid_i`  in  1  sample_i valid (dsp `done`)
- `sample_ready_o`  out  1  holding register empty
- `bclk_o`  out  1  I2S bit clock
- `lrclk_o`  out  1  I2S word select; 0 = left, 1 = right
- `sdata_o`  out  1  I2S serial data, MSB first
- `frame_start_o`  out  1  one-clk pulse when a word is loaded for a new frame
- `underrun_o`  out  1  sticky: frame started with no sample available
- `overrun_o`  out  1  sticky: valid asserted while not ready

## Operation
- Holding register (1 entry) + 32-bit shift register + divider counter + 6-bit bit counter (0–63).
- Handshake: transfer when `sample_valid_i & sample_ready_o`; `sample_ready_o = !full` (combinational from state). Valid while not ready: sample dropped, `overrun_o` set.
- Scaling: `s = sample_i >>> SHIFT` (sign-preserving); saturate to [−2^23, 2^23−1] (0x800000 / 0x7FFFFF); result 24 bits.
- Slot format: 32 BCLKs per slot, 64 per frame; 24 data bits then 8 zero bits; same word in left and right slots.
- Load event: BCLK falling edge at which bit counter wraps 63→0 (lrclk_o goes 1→0). On load:
  - holding full: word → shift register, holding cleared, `frame_start_o` pulse.
  - holding empty, valid same cycle: incoming sample bypasses directly into shift register, no underrun.
  - holding empty, no valid: previous word repeated, `underrun_o` set, `frame_start_o` still pulses.
- Right slot reloads the same word at bit counter 31→32.
- Sticky flags cleared only by reset.
- Reset mid-frame: all state cleared immediately; current word discarded.

## Timing
- Reset values: `bclk_o`=0, `lrclk_o`=1, `sdata_o`=0, `sample_ready_o`=1, `frame_start_o`=0, `underrun_o`=0, `overrun_o`=0, counters 0, shift/holding/last word 0.
- `bclk_o` toggles every `CLK_DIV` enabled clks; frame = 128·CLK_DIV clks (512 default).
- `lrclk_o` and `sdata_o` change only on the clk where `bclk_o` goes 1→0; DAC samples on BCLK rise.
- I2S one-bit delay: `lrclk_o` changes one BCLK before the slot's MSB; MSB driven on the falling edge following the LRCLK transition; the bit at the LRCLK edge is the previous slot's final (zero) bit.
- First LRCLK 1→0 occurs at the 64th BCLK falling edge after reset release.
- Latency: sample accepted during frame N appears on `sdata_o` at the start of frame N+1 (bypass case: same frame).
- `en_i` low: divider, counters, outputs hold; handshake still accepted into the holding register.

## Configuration
- `I2S_TX_SATURATE_EN` defined: clamp to 24-bit range as above.
- Not defined: plain truncation to low 24 bits of `s` (wraps on overflow); saturation logic absent.

## Test plan
- Reset, CLK_DIV=4: all outputs at reset values; first `frame_start_o` at 64 BCLK falls; `bclk_o` period 8 clks.
- SHIFT=8, `sample_i`=33'h000001200 → left and right slots both carry 24'h000012, then 8 zeros; MSB one BCLK after LRCLK edge.
- Saturation: `sample_i`=33'h0FFFFFFFF → 24'h7FFFFF; 33'h100000000 → 24'h800000; without macro → 24'hFFFFFF / 24'h000000.
- Two valids back-to-back without a frame boundary → second dropped, `overrun_o`=1; `sample_ready_o` low until next load.
- No sample for one frame → previous word repeated, `underrun_o`=1; valid exactly on load clk with empty holding → transmitted that frame, no underrun.
- Reset asserted mid-left-slot → outputs return to reset values within the same clk, no clk edge required.
